// File: rtl/cache_fill_pkg.sv
// Shared types and width helpers for the cache miss-fill controller.
// Imported by the fill controller and its arbiter.
package cache_fill_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  function automatic int offset_w(input int words, input int data_w);
    return $clog2(words * (data_w / 8));
  endfunction

  function automatic int idx_w(input int words);
    return $clog2(words);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past last_grant.
// Purely combinational; last_grant is held by the parent.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  input  logic                 enable,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_grant) + k) % N);
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss-fill controller: arbitrates missing caches and streams one
// block per fill from a pipelined word-wide memory.
module cache_fill_ctrl
  import cache_fill_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int WORDS_PER_BLK = 8,
  parameter int NUM_REQ       = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          miss_detected,
  input  logic [NUM_REQ*ADDR_W-1:0]   miss_addr,
  output logic [NUM_REQ-1:0]          fsm_busy,
  output logic [NUM_REQ-1:0]          write_data_array,
  output logic [NUM_REQ-1:0]          write_tag_array,
  output logic [ADDR_W-1:0]           fill_base_addr,
  output logic [$clog2(WORDS_PER_BLK)-1:0] fill_word_idx,
  output logic [DATA_W-1:0]           fill_data,
  output logic                        mem_en,
  output logic [ADDR_W-1:0]           memory_address,
  output logic                        mem_owned,
  input  logic [DATA_W-1:0]           memory_data,
  input  logic                        memory_data_valid
);

  localparam int BYTES    = DATA_W / 8;
  localparam int OFFSET_W = offset_w(WORDS_PER_BLK, DATA_W);
  localparam int IDX_W    = idx_w(WORDS_PER_BLK);
  localparam int REQ_W    = $clog2(NUM_REQ);

  localparam logic [IDX_W:0]    REQ_END  = (IDX_W+1)'(WORDS_PER_BLK);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS_PER_BLK - 1);
  localparam logic [ADDR_W-1:0] BLK_MASK =
    ~ADDR_W'((64'd1 << OFFSET_W) - 64'd1);

  state_e             state, state_n;
  logic [IDX_W:0]     req_cnt, req_cnt_n;
  logic [IDX_W-1:0]   recv_cnt, recv_cnt_n;
  logic [REQ_W-1:0]   owner, owner_n;
  logic [REQ_W-1:0]   last_grant, last_grant_n;
  logic [REQ_W-1:0]   grant_idx;
  logic [ADDR_W-1:0]  base, base_n;
  logic [ADDR_W-1:0]  sel_addr;
  logic [NUM_REQ-1:0] grant, owner_oh;
  logic [OFFSET_W-1:0] offset;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req        (miss_detected),
    .last_grant (last_grant),
    .enable     (state == IDLE),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign sel_addr  = miss_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign owner_oh  = NUM_REQ'(1) << owner;
  assign mem_owned = (state == FILL);
  assign fsm_busy  = miss_detected | (mem_owned ? owner_oh : '0);

  // Offset never carries past the block, so OR-ing into base is exact.
  assign offset = OFFSET_W'(req_cnt[IDX_W-1:0]) * OFFSET_W'(BYTES);
  assign memory_address = base | ADDR_W'(offset);

  assign fill_base_addr = base;
  assign fill_word_idx  = recv_cnt;
  assign fill_data      = memory_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_cnt    <= '0;
      recv_cnt   <= '0;
      owner      <= '0;
      base       <= '0;
      last_grant <= REQ_W'(NUM_REQ - 1);
    end else begin
      state      <= state_n;
      req_cnt    <= req_cnt_n;
      recv_cnt   <= recv_cnt_n;
      owner      <= owner_n;
      base       <= base_n;
      last_grant <= last_grant_n;
    end
  end

  always_comb begin
    state_n          = state;
    req_cnt_n        = req_cnt;
    recv_cnt_n       = recv_cnt;
    owner_n          = owner;
    base_n           = base;
    last_grant_n     = last_grant;
    mem_en           = 1'b0;
    write_data_array = '0;
    write_tag_array  = '0;
    unique case (1'b1)
      (state == IDLE): begin
        if (|grant) begin
          owner_n      = grant_idx;
          last_grant_n = grant_idx;
          base_n       = sel_addr & BLK_MASK;
          req_cnt_n    = '0;
          recv_cnt_n   = '0;
          state_n      = FILL;
        end
      end
      (state == FILL): begin
        if (req_cnt < REQ_END) begin
          mem_en    = 1'b1;
          req_cnt_n = req_cnt + 1'b1;
        end
        if (memory_data_valid) begin
          write_data_array[owner] = 1'b1;
          recv_cnt_n = recv_cnt + 1'b1;
          if (recv_cnt == LAST_IDX) begin
            write_tag_array[owner] = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: transaction model drives
// misses and memory returns, monitor checks DUT outputs.
module tb_cache_fill_ctrl;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int W   = 8;
  localparam int N   = 2;
  localparam int LAT = 4;
  localparam int BY  = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    miss_detected;
  logic [N*AW-1:0] miss_addr;
  logic [N-1:0]    fsm_busy, write_data_array, write_tag_array;
  logic [AW-1:0]   fill_base_addr, memory_address;
  logic [2:0]      fill_word_idx;
  logic [DW-1:0]   fill_data, memory_data;
  logic            mem_en, mem_owned, memory_data_valid;

  cache_fill_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLK(W), .NUM_REQ(N)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_addr         (miss_addr),
    .fsm_busy          (fsm_busy),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .fill_base_addr    (fill_base_addr),
    .fill_word_idx     (fill_word_idx),
    .fill_data         (fill_data),
    .mem_en            (mem_en),
    .memory_address    (memory_address),
    .mem_owned         (mem_owned),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    bit           chk;
    logic [N-1:0] busy;
    bit           owned;
    logic [AW-1:0] base;
  } cyc_t;
  typedef struct { int cyc; logic [AW-1:0] addr; } req_t;
  typedef struct {
    int cyc; int owner; int idx; logic [DW-1:0] data; bit tag;
  } wr_t;
  typedef struct { int due; logic [DW-1:0] data; bit stale; } ret_t;

  cyc_t cyc_q[$];
  req_t req_q[$];
  wr_t  wr_q[$];
  ret_t ret_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = -1;

  // transaction-level model of the fill engine
  bit            m_fill = 0;
  int            m_owner = 0, m_last = N - 1;
  int            m_req_k = 0, m_ret_k = 0, last_due = 0;
  logic [AW-1:0] m_base = '0;

  logic [N-1:0]  md = '0;
  logic [AW-1:0] maddr [N];
  bit   [N-1:0]  clr_next = '0;
  bit   [N-1:0]  auto_remiss = '0;
  bit            rand_miss = 0;
  bit            chk_on = 0;
  int            gap_mode = 0;
  int            gap_pat [W];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h",
               name, cyc, act, exp);
    end
  endtask

  task automatic fail_evt(string name, int at, logic [63:0] v);
    vectors++;
    miscompares++;
    $display("FAIL %s cycle %0d: got value %0h, expected none/other",
             name, at, v);
  endtask

  function automatic int gap(int k);
    if (gap_mode == 1) return gap_pat[k];
    if (gap_mode == 2)
      return ($urandom_range(3) == 0) ? int'($urandom_range(2)) : 0;
    return 0;
  endfunction

  task automatic step(bit do_rst);
    ret_t          r;
    cyc_t          e;
    bit            ret_now, hold, got;
    logic [N-1:0]  mdv;
    int            due, pick;
    @(posedge clk);
    #1;
    cyc++;
    rst = do_rst;
    ret_now = 0;
    memory_data_valid = 1'b0;
    memory_data = DW'($urandom);
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      r = ret_q.pop_front();
      memory_data_valid = 1'b1;
      memory_data = r.data;
      ret_now = !r.stale;
    end
    hold = 0;
    foreach (ret_q[j]) if (ret_q[j].stale) hold = 1;
    for (int i = 0; i < N; i++) begin
      if (clr_next[i]) md[i] = 1'b0;
      if (!md[i] && (auto_remiss[i] ||
          (rand_miss && $urandom_range(3) == 0))) begin
        md[i] = 1'b1;
        maddr[i] = AW'($urandom);
      end
    end
    clr_next = '0;
    mdv = (do_rst || hold) ? '0 : md;
    miss_detected = mdv;
    for (int i = 0; i < N; i++) miss_addr[i*AW +: AW] = maddr[i];

    e.cyc = cyc;
    e.chk = chk_on;
    e.owned = m_fill;
    e.base = m_base;
    e.busy = mdv | (m_fill ? N'(1) << m_owner : '0);
    if (m_fill) begin
      if (m_req_k < W) begin
        req_q.push_back('{cyc, m_base + AW'(m_req_k * BY)});
        due = (cyc + LAT > last_due + 1) ? cyc + LAT : last_due + 1;
        due += gap(m_req_k);
        ret_q.push_back('{due, DW'($urandom), 1'b0});
        last_due = due;
        m_req_k++;
      end
      if (ret_now) begin
        wr_q.push_back('{cyc, m_owner, m_ret_k, memory_data,
                         m_ret_k == W - 1});
        if (m_ret_k == W - 1) begin
          m_fill = 0;
          clr_next[m_owner] = 1'b1;
        end
        m_ret_k++;
      end
    end else if (mdv != '0) begin
      got = 0;
      pick = 0;
      for (int k = 1; k <= N; k++) begin
        if (!got && mdv[(m_last + k) % N]) begin
          got = 1;
          pick = (m_last + k) % N;
        end
      end
      m_owner = pick;
      m_last = pick;
      m_base = maddr[pick] & ~AW'(W * BY - 1);
      m_req_k = 0;
      m_ret_k = 0;
      m_fill = 1;
    end
    if (do_rst) begin
      m_fill = 0;
      m_last = N - 1;
      m_base = '0;
      md = '0;
      clr_next = '0;
      foreach (ret_q[j]) ret_q[j].stale = 1'b1;
      chk_on = 1;
    end
    cyc_q.push_back(e);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  cyc_t mon_e;
  req_t mon_r;
  wr_t  mon_w;
  logic [N-1:0] tag_exp;

  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      mon_e = cyc_q.pop_front();
      if (mon_e.chk) begin
        check("fsm_busy", fsm_busy, mon_e.busy);
        check("mem_owned", mem_owned, mon_e.owned);
        check("fill_base_addr", fill_base_addr, mon_e.base);
        if (mem_en) begin
          if (req_q.size() > 0 && req_q[0].cyc == mon_e.cyc) begin
            mon_r = req_q.pop_front();
            check("memory_address", memory_address, mon_r.addr);
          end else begin
            fail_evt("unexpected_mem_en", mon_e.cyc, memory_address);
          end
        end
        if (|write_data_array || |write_tag_array) begin
          if (wr_q.size() > 0 && wr_q[0].cyc == mon_e.cyc) begin
            mon_w = wr_q.pop_front();
            tag_exp = mon_w.tag ? N'(1) << mon_w.owner : '0;
            check("write_data_array", write_data_array,
                  N'(1) << mon_w.owner);
            check("fill_word_idx", fill_word_idx, mon_w.idx);
            check("fill_data", fill_data, mon_w.data);
            check("write_tag_array", write_tag_array, tag_exp);
          end else begin
            fail_evt("unexpected_write", mon_e.cyc,
                     {write_tag_array, write_data_array});
          end
        end
      end
      while (req_q.size() > 0 && req_q[0].cyc <= mon_e.cyc) begin
        mon_r = req_q.pop_front();
        if (mon_e.chk) fail_evt("missing_request", mon_r.cyc, mon_r.addr);
      end
      while (wr_q.size() > 0 && wr_q[0].cyc <= mon_e.cyc) begin
        mon_w = wr_q.pop_front();
        if (mon_e.chk) fail_evt("missing_write", mon_w.cyc, mon_w.idx);
      end
    end
  end

  initial begin
    rst = 1'b1;
    miss_detected = '0;
    miss_addr = '0;
    memory_data = '0;
    memory_data_valid = 1'b0;
    for (int i = 0; i < N; i++) maddr[i] = '0;
    for (int i = 0; i < W; i++) gap_pat[i] = 0;
    step(1'b1);
    step(1'b1);

    md = 2'b10; maddr[1] = 16'h1234;
    run(16);

    md = 2'b11; maddr[0] = 16'h0100; maddr[1] = 16'h2200;
    run(30);

    md = 2'b11; maddr[0] = 16'h0A00; maddr[1] = 16'h0B40;
    auto_remiss = 2'b01;
    run(40);
    auto_remiss = '0;
    run(30);

    md = 2'b01; maddr[0] = 16'hFFFB;
    run(16);

    gap_mode = 1;
    gap_pat[1] = 1;
    gap_pat[3] = 1;
    md = 2'b10; maddr[1] = 16'h4A5E;
    run(18);
    gap_mode = 0;

    md = 2'b10; maddr[1] = 16'h7770;
    run(6);
    step(1'b1);
    run(12);
    md = 2'b11; maddr[0] = 16'h3333; maddr[1] = 16'h5555;
    run(30);

    rand_miss = 1;
    gap_mode = 2;
    run(800);
    rand_miss = 0;
    for (int i = 0; i < 400 && (md != '0 || m_fill || ret_q.size() > 0);
         i++)
      step(1'b0);
    if (md != '0 || m_fill || ret_q.size() > 0)
      fail_evt("drain_timeout", cyc, md);
    run(3);
    @(negedge clk);
    #1;
    while (req_q.size() > 0) begin
      mon_r = req_q.pop_front();
      fail_evt("leftover_request", mon_r.cyc, mon_r.addr);
    end
    while (wr_q.size() > 0) begin
      mon_w = wr_q.pop_front();
      fail_evt("leftover_write", mon_w.cyc, mon_w.idx);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Parametrised cache miss-fill controller shared by several caches (default: I-cache and D-cache) behind one word-wide, pipelined main memory. It arbitrates between missing caches round-robin and issues one memory read per cycle for every word of the missing block. It writes each returned word into the owning cache's data array and writes the tag with the last word. It sits between the cache tag/data arrays and the memory port, and its per-requester busy outputs stall the pipeline.

## Interface
- ADDR_W, 16, byte address width
- DATA_W, 16, word width in bits, multiple of 8
- WORDS_PER_BLK, 8, words per cache block, power of 2, ≥2
- NUM_REQ, 2, number of requesting caches, ≥2 (index 0 = D-cache, 1 = I-cache)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- miss_detected  in  NUM_REQ  bit i: cache i has a miss, held until its tag is written
- miss_addr  in  NUM_REQ*ADDR_W  slice i: miss byte address of cache i
- fsm_busy  out  NUM_REQ  bit i: stall cache i
- write_data_array  out  NUM_REQ  bit i: write fill_data at fill_word_idx into cache i this cycle
- write_tag_array  out  NUM_REQ  bit i: write tag of fill_base_addr into cache i this cycle
- fill_base_addr  out  ADDR_W  block-aligned address of the block being filled
- fill_word_idx  out  log2(WORDS_PER_BLK)  word index within the block for the current data write
- fill_data  out  DATA_W  word to write, combinational pass-through of memory_data
- mem_en  out  1  memory read request this cycle
- memory_address  out  ADDR_W  read address
- mem_owned  out  1  memory port owned by the fill; external write-through path must yield
- memory_data  in  DATA_W  returned read data
- memory_data_valid  in  1  memory_data valid this cycle, in request order

## Operation
- Derived constants: BYTES = DATA_W/8; OFFSET_W = clog2(WORDS_PER_BLK*BYTES).
- States: IDLE, FILL.
- IDLE, any miss_detected set:
  - Grant one requester round-robin. The search starts at last_grant+1 mod NUM_REQ.
  - Capture owner = grant.
  - Capture base = miss_addr[grant] with the low OFFSET_W bits cleared.
  - Update last_grant and go to FILL.
- FILL, requests:
  - mem_en = 1 while req_cnt < WORDS_PER_BLK.
  - memory_address = base + req_cnt*BYTES.
  - req_cnt increments each issuing cycle.
- FILL, returns:
  - Each memory_data_valid sets write_data_array[owner] = 1, with fill_word_idx = recv_cnt, and increments recv_cnt.
  - On the valid with recv_cnt = WORDS_PER_BLK-1, write_tag_array[owner] = 1 in the same cycle and go to IDLE.
- Returns that do not arrive on consecutive cycles pause recv_cnt only. Requests are never throttled.
- fsm_busy[i] = miss_detected[i] | (state==FILL & owner==i), combinational.
- mem_owned = (state==FILL).
- write_* outputs are 0 outside FILL.
- memory_data_valid in IDLE is ignored, with no writes.
- Address arithmetic: base + req_cnt*BYTES never carries out of the block. Only the offset bits change, so the upper bits stay equal to base.
- A requester not granted keeps miss_detected asserted and stays stalled. It is served in a later IDLE cycle.
- Reset (any state):
  - state=IDLE; req_cnt, recv_cnt, owner, base = 0; last_grant = NUM_REQ-1, so requester 0 wins first.
  - Every registered output reads 0 the cycle after reset.
  - Returns still in flight after reset are dropped.

## Timing
- Miss seen in IDLE at cycle 0. FILL starts at cycle 1.
- Requests in cycles 1..WORDS_PER_BLK.
- Data writes coincide with valid pulses. Tag write coincides with the last data write.
- IDLE again the cycle after the tag write. A new grant is possible in that IDLE cycle, and FILL follows one cycle later.
- With 4-cycle memory, default parameters, and no gaps: busy cycles 0..12, IDLE at 13.
- fill_data, fill_word_idx and the write strobes are valid in the same cycle as memory_data_valid. The cache arrays capture them at that clock edge.

## Structure
- Package cache_fill_pkg:
  - state enum {IDLE, FILL}
  - OFFSET_W / word-index width helper functions
- Sub-module rr_arbiter (parameter N): inputs req[N], last_grant, enable; outputs a one-hot grant and a binary index. Combinational apart from nothing; last_grant is stored in the parent.
- Parent holds state, counters, owner, base, last_grant.

## Test plan
All scenarios use default parameters and a pipelined memory model with 4-cycle latency.
- Single miss: miss_detected=2'b10, miss_addr[1]=0x1234 →
  - fill_base_addr=0x1230; mem_en cycles 1–8 with addresses 0x1230, 0x1232 … 0x123E.
  - write_data_array[1] cycles 5–12 with idx 0..7.
  - write_tag_array[1] only in cycle 12; fsm_busy[1] high cycles 0–12; fsm_busy[0]=0 throughout.
- Both miss together after reset (0x0100, 0x2200) → requester 0 filled first (base 0x0100). Requester 1 is granted in the cycle-13 IDLE, and requests 0x2200 from cycle 14.
- Fairness: requester 0 re-misses immediately after its fill while requester 1 is waiting → requester 1 is granted next.
- Wrap: miss_addr 0xFFFB → base 0xFFF0; last request 0xFFFE; no address carry.
- Gapped returns: valid pulses at cycles 5, 7, 8, 10–14 → idx 0..7 in order; tag write at cycle 14; busy until 14.
- Reset asserted at cycle 6 of a fill:
  - Next cycle: mem_en=0 and all write strobes 0.
  - Late valid pulses cause no writes.
  - Next miss starts a fresh fill at word 0, granted to requester 0.
